// File: rtl/ascii_num_tokenizer.sv
// Splits an ASCII byte stream into signed decimal tokens, drives the ASCII-to-int32 converter
// for each token and hands the converted value downstream over valid/ready.
module ascii_num_tokenizer #(
    parameter int unsigned COUNT_W    = 16,
    parameter int unsigned MAX_DIGITS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               cvt_start,
    output logic [7:0]         cvt_char,
    output logic               cvt_char_valid,
    output logic               cvt_num_end,
    input  logic [31:0]        cvt_result,
    input  logic               cvt_result_valid,
    output logic [31:0]        num_out,
    output logic               num_valid,
    input  logic               num_ready,
    output logic               line_done,
    output logic [COUNT_W-1:0] line_count,
    output logic               err_char,
    output logic               err_overflow
);

    localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [DCNT_W-1:0] MaxDigits = DCNT_W'(MAX_DIGITS);

    typedef enum logic [2:0] {StIdle, StStart, StFirst, StFeed, StWait, StPush} state_e;

    state_e              state_q, state_d;
    logic [7:0]          pending_q, pending_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                term_q, term_d;
    logic [COUNT_W-1:0]  tok_q, tok_d, line_q, line_d, tok_inc;
    logic [31:0]         num_q, num_d;
    logic                accept, in_digit, in_minus, in_sep, in_term;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    assign rx_ready   = (state_q == StIdle) || (state_q == StFeed);
    assign accept     = rx_valid && rx_ready;
    assign in_digit   = is_digit(rx_data);
    assign in_minus   = (rx_data == 8'h2D);
    assign in_sep     = (rx_data == 8'h20) || (rx_data == 8'h2C);
    assign in_term    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign tok_inc    = (tok_q == '1) ? tok_q : tok_q + 1'b1;
    assign num_out    = num_q;
    assign num_valid  = (state_q == StPush);
    // line_d only differs from line_q in the line_done cycle, so this is valid with the pulse
    assign line_count = line_d;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        dcnt_d         = dcnt_q;
        term_d         = term_q;
        tok_d          = tok_q;
        line_d         = line_q;
        num_d          = num_q;
        cvt_start      = 1'b0;
        cvt_char       = 8'h00;
        cvt_char_valid = 1'b0;
        cvt_num_end    = 1'b0;
        line_done      = 1'b0;
        err_char       = 1'b0;
        err_overflow   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_digit || in_minus) begin
                        pending_d = rx_data;
                        state_d   = StStart;
                    end else if (in_term) begin
                        if (tok_q != '0) begin
                            line_done = 1'b1;
                            line_d    = tok_q;
                            tok_d     = '0;
                        end
                    end else if (!in_sep) begin
                        err_char = 1'b1;
                    end
                end
            end
            StStart: begin
                cvt_start = 1'b1;
                state_d   = StFirst;
            end
            StFirst: begin
                cvt_char       = pending_q;
                cvt_char_valid = 1'b1;
                dcnt_d         = is_digit(pending_q) ? DCNT_W'(1) : '0;
                state_d        = StFeed;
            end
            StFeed: begin
                cvt_char = rx_data;
                if (accept) begin
                    if (in_digit) begin
                        cvt_char_valid = 1'b1;
                        // Counter parks at MAX_DIGITS+1 so the overflow pulse fires once per token
                        if (dcnt_q <= MaxDigits) dcnt_d = dcnt_q + 1'b1;
                        if (dcnt_q == MaxDigits) err_overflow = 1'b1;
                    end else if (in_sep || in_term) begin
                        cvt_num_end = 1'b1;
                        term_d      = in_term;
                        state_d     = StWait;
                    end else begin
                        err_char = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cvt_result_valid) begin
                    num_d   = cvt_result;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (num_ready) begin
                    if (term_q) begin
                        line_done = 1'b1;
                        line_d    = tok_inc;
                        tok_d     = '0;
                    end else begin
                        tok_d = tok_inc;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            dcnt_q    <= '0;
            term_q    <= 1'b0;
            tok_q     <= '0;
            line_q    <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dcnt_q    <= dcnt_d;
            term_q    <= term_d;
            tok_q     <= tok_d;
            line_q    <= line_d;
            num_q     <= num_d;
        end
    end

endmodule

// File: tb/tb_ascii_num_tokenizer.sv
// Directed bench for ascii_num_tokenizer: a token-level reference model plus a converter model,
// with per-cycle protocol checks and literal expectations for each stimulus string.
module tb_ascii_num_tokenizer;

    localparam int unsigned COUNT_W    = 16;
    localparam int unsigned MAX_DIGITS = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               rx_ready;
    logic               cvt_start;
    logic [7:0]         cvt_char;
    logic               cvt_char_valid;
    logic               cvt_num_end;
    logic [31:0]        cvt_result;
    logic               cvt_result_valid;
    logic [31:0]        num_out;
    logic               num_valid;
    logic               num_ready = 1'b0;
    logic               line_done;
    logic [COUNT_W-1:0] line_count;
    logic               err_char;
    logic               err_overflow;

    ascii_num_tokenizer #(.COUNT_W(COUNT_W), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cvt_start(cvt_start), .cvt_char(cvt_char), .cvt_char_valid(cvt_char_valid),
        .cvt_num_end(cvt_num_end), .cvt_result(cvt_result), .cvt_result_valid(cvt_result_valid),
        .num_out(num_out), .num_valid(num_valid), .num_ready(num_ready),
        .line_done(line_done), .line_count(line_count),
        .err_char(err_char), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Converter: accumulates chars, answers two cycles after num_end
    logic [31:0] cv_acc, cv_p1_val;
    logic        cv_neg, cv_p1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_acc <= 32'd0; cv_neg <= 1'b0; cv_p1 <= 1'b0; cv_p1_val <= 32'd0;
            cvt_result <= 32'd0; cvt_result_valid <= 1'b0;
        end else begin
            cv_p1            <= cvt_num_end;
            cvt_result_valid <= cv_p1;
            if (cvt_num_end) cv_p1_val <= cv_neg ? -cv_acc : cv_acc;
            if (cv_p1) cvt_result <= cv_p1_val;
            if (cvt_start) begin
                cv_acc <= 32'd0;
                cv_neg <= 1'b0;
            end else if (cvt_char_valid) begin
                if (cvt_char == 8'h2D) cv_neg <= 1'b1;
                else cv_acc <= cv_acc * 32'd10 + {24'd0, cvt_char - 8'h30};
            end
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic lit(input string name, input longint act, input longint exp);
        check(act == exp, name, act, exp);
    endtask

    // Token-level reference model
    int          exp_nums[$];
    int          exp_lines[$];
    int          exp_errc, exp_ovf;
    bit          m_in_tok, m_neg;
    logic [31:0] m_val;
    int          m_digits, m_line;

    function automatic bit is_dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic bit is_sep(input logic [7:0] c);
        return c == 8'h20 || c == 8'h2C;
    endfunction
    function automatic bit is_term(input logic [7:0] c);
        return c == 8'h0D || c == 8'h0A;
    endfunction

    task automatic model_clear();
        exp_nums.delete(); exp_lines.delete();
        exp_errc = 0; exp_ovf = 0; m_in_tok = 0; m_line = 0;
    endtask

    task automatic model_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (!m_in_tok) begin
                if (is_dig(c) || c == 8'h2D) begin
                    m_in_tok = 1;
                    m_neg    = (c == 8'h2D);
                    m_val    = is_dig(c) ? 32'(c - 8'h30) : 32'd0;
                    m_digits = is_dig(c) ? 1 : 0;
                end else if (is_term(c)) begin
                    if (m_line > 0) exp_lines.push_back(m_line);
                    m_line = 0;
                end else if (!is_sep(c)) begin
                    exp_errc++;
                end
            end else if (is_dig(c)) begin
                m_digits++;
                if (m_digits == int'(MAX_DIGITS) + 1) exp_ovf++;
                m_val = m_val * 32'd10 + 32'(c - 8'h30);
            end else if (is_sep(c) || is_term(c)) begin
                exp_nums.push_back(int'(m_neg ? -m_val : m_val));
                m_in_tok = 0;
                if (m_line < 65535) m_line++;
                if (is_term(c)) begin
                    exp_lines.push_back(m_line);
                    m_line = 0;
                end
            end else begin
                exp_errc++;
            end
        end
    endtask

    // Downstream ready generator and per-cycle checker
    int          ready_wait = 0;
    int          rdy_cnt = 0;
    int          cyc = 0;
    int          end_cyc = -10;
    int          errc_seen, ovf_seen, lines_seen;
    int          got_nums[$];
    int          last_line;
    bit          prev_valid, prev_ready, prev_accept, prev_start;
    logic [31:0] held;

    always @(negedge clk) begin
        if (num_valid) begin
            num_ready = (rdy_cnt >= ready_wait);
            rdy_cnt++;
        end else begin
            num_ready = 1'b0;
            rdy_cnt   = 0;
        end
        #1;
        cyc++;
        if (rst_n) begin
            if (cvt_num_end) end_cyc = cyc;
            if (num_valid && !prev_valid)
                check(cyc == end_cyc + 3, "num_valid_latency", cyc - end_cyc, 3);
            if (cyc == end_cyc + 1 || cyc == end_cyc + 2)
                check(!rx_ready, "rx_ready_low_wait", rx_ready, 0);
            if (cvt_start)
                check(prev_accept && !rx_ready, "start_after_accept", prev_accept, 1);
            if (cvt_char_valid && !rx_ready)
                check(prev_start, "first_after_start", prev_start, 1);
            if (num_valid) check(!rx_ready, "rx_ready_low_push", rx_ready, 0);
            if (num_valid && prev_valid && !prev_ready)
                check(num_out == held, "num_out_stable", num_out, held);
            if (num_valid && num_ready) begin
                if (exp_nums.size() == 0) begin
                    check(0, "unexpected_token", int'(num_out), 0);
                end else begin
                    int e;
                    e = exp_nums.pop_front();
                    check(int'(num_out) == e, "token_value", int'(num_out), e);
                    got_nums.push_back(int'(num_out));
                end
            end
            if (line_done) begin
                lines_seen++;
                last_line = int'(line_count);
                if (exp_lines.size() == 0) begin
                    check(0, "unexpected_line_done", line_count, 0);
                end else begin
                    int e;
                    e = exp_lines.pop_front();
                    check(int'(line_count) == e, "line_count", line_count, e);
                end
            end
            if (err_char) errc_seen++;
            if (err_overflow) ovf_seen++;
            prev_valid  = num_valid;
            prev_ready  = num_ready;
            held        = num_out;
            prev_accept = rx_valid && rx_ready;
            prev_start  = cvt_start;
        end else begin
            prev_valid = 0; prev_ready = 0; prev_accept = 0; prev_start = 0; end_cyc = -10;
        end
    end

    // All driver tasks start and end just after a falling edge
    task automatic send(input logic [7:0] c);
        bit acc = 0;
        int n = 0;
        rx_data  = c;
        rx_valid = 1'b1;
        while (!acc) begin
            acc = rx_ready;
            @(negedge clk);
            n++;
            if (n > 200) begin
                check(0, "rx_accept_timeout", n, 200);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic run(input string s, input int rw);
        int n = 0;
        do_reset();
        ready_wait = rw;
        errc_seen = 0; ovf_seen = 0; lines_seen = 0; last_line = -1;
        got_nums.delete();
        model_str(s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        while ((exp_nums.size() != 0 || num_valid || !rx_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(0, "drain_timeout", n, 300);
        repeat (3) @(negedge clk);
        check(exp_lines.size() == 0, "missing_line_done", exp_lines.size(), 0);
        check(errc_seen == exp_errc, "err_char_count", errc_seen, exp_errc);
        check(ovf_seen == exp_ovf, "err_overflow_count", ovf_seen, exp_ovf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        #2;
        lit("reset_rx_ready", rx_ready, 1);
        lit("reset_num_valid", num_valid, 0);
        lit("reset_num_out", num_out, 0);
        lit("reset_line_count", line_count, 0);
        lit("reset_cvt_ctrl", {cvt_start, cvt_char_valid, cvt_num_end}, 0);
        lit("reset_cvt_char", cvt_char, 0);
        lit("reset_err", {err_char, err_overflow, line_done}, 0);
        @(negedge clk);

        run("123 ", 0);
        lit("t1_count", got_nums.size(), 1);
        lit("t1_value", got_nums[0], 123);

        run("-45,7\n", 0);
        lit("t2_count", got_nums.size(), 2);
        lit("t2_first", got_nums[0], -45);
        lit("t2_second", got_nums[1], 7);
        lit("t2_line", last_line, 2);
        lit("t2_no_err", errc_seen + ovf_seen, 0);

        run("1 2 3\r\n", 5);
        lit("t3_count", got_nums.size(), 3);
        lit("t3_line", last_line, 3);
        lit("t3_single_line_done", lines_seen, 1);
        lit("t3_line_count_held", line_count, 3);

        run("9x8 ", 0);
        lit("t4_value", got_nums[0], 98);
        lit("t4_err_char", errc_seen, 1);

        run("a\n", 0);
        lit("t5_err_char", errc_seen, 1);
        lit("t5_no_line", lines_seen, 0);

        run("12345678901 ", 1);
        lit("t6_value", got_nums[0], -539222987);
        lit("t6_overflow", ovf_seen, 1);

        run("- ", 0);
        lit("t7_count", got_nums.size(), 1);
        lit("t7_value", got_nums[0], 0);

        do_reset();
        send(8'h37);
        send(8'h37);
        rst_n = 1'b0;
        #2;
        lit("midreset_num_valid", num_valid, 0);
        lit("midreset_rx_ready", rx_ready, 1);
        lit("midreset_cvt", {cvt_start, cvt_char_valid, cvt_num_end}, 0);
        lit("midreset_cvt_char", cvt_char, 0);
        repeat (3) @(negedge clk);
        run("5 ", 0);
        lit("t8_count", got_nums.size(), 1);
        lit("t8_value", got_nums[0], 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
